carry_select_adder_32: RTL and testbench
========================================

CARRY_SELECT_ADDER_32 -- requirements
Module: carry_select_adder_32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL expose parameter WIDTH, default 32: operand and sum width in bits.
REQ-003 The block SHALL expose parameter BLOCK, default 4: carry-select group width in bits; WIDTH SHALL be an integer multiple of BLOCK.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port a, input, WIDTH bits: first operand, unsigned or two's complement.
REQ-007 Port b, input, WIDTH bits: second operand.
REQ-008 Port cin, input, 1 bit: carry-in to bit 0.
REQ-009 Port sum, output, WIDTH bits: registered a + b + cin, modulo 2^WIDTH.
REQ-010 Port cout, output, 1 bit: registered carry-out of bit WIDTH-1.
REQ-011 Port OF, output, 1 bit: registered signed two's-complement overflow flag.

Function
REQ-012 On each rising clk edge with rst low, the block SHALL sample a, b and cin and register sum, cout and OF for that sample.
REQ-013 Latency SHALL be exactly 1 cycle, with a new result every cycle and no handshake or stall.
REQ-014 The arithmetic SHALL satisfy {cout, sum} = a + b + cin, zero-extended to WIDTH+1 bits.
REQ-015 OF SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
- Equivalently, OF is 1 when both operands have the same sign and the sign of sum differs from it.
REQ-016 Wrap-around: an all-ones operand plus 1 SHALL give sum 0 and cout 1; 0x7FFFFFFF + 1 SHALL give OF 1 and cout 0.
REQ-017 Outputs SHALL hold their values between edges; input glitches between edges SHALL have no effect.
REQ-018 The combinational adder SHALL use a carry-select structure:
- group 0 (bits BLOCK-1:0) is a ripple-carry adder fed by cin;
- every other group computes two ripple sums, one assuming carry-in 0 and one assuming carry-in 1;
- the incoming group carry selects one sum and one carry-out through multiplexers.
REQ-019 The overflow calculation SHALL use the internal carry into the MSB from within the last group.

Reset
REQ-020 When rst is high at a rising clk edge, sum SHALL become 0, cout 0 and OF 0.
REQ-021 Reset SHALL take priority over loading new inputs in the same cycle.
REQ-022 If reset is asserted mid-stream, the in-flight result SHALL be discarded.
REQ-023 The first valid result after reset SHALL appear 1 cycle after the first edge with rst low.
REQ-024 There SHALL be no asynchronous reset path.

Structure
REQ-025 A shared package SHALL hold the WIDTH and BLOCK defaults and a derived constant NUM_GROUPS = WIDTH/BLOCK.
REQ-026 One sub-module, rca_block, SHALL be used.
- It is a BLOCK-bit ripple-carry adder with inputs x, y and ci, and outputs s, co and c_msb (carry into its MSB).
- It is instantiated once for group 0 and twice for each other group.
REQ-027 The group multiplexers and the output registers SHALL live in the top module; no latches are permitted.

Verification
REQ-028 Scenario 1: a=0x5FFFE8CA, b=0x54F4FFFF, cin=0 -> after 1 cycle, sum=0xB4F4E8C9, cout=0, OF=1.
REQ-029 Scenario 2: a=0xA0A0FFFF, b=0xA0BFFFE0, cin=0 -> sum=0x4160FFDF, cout=1, OF=1.
REQ-030 Scenario 3: a=0x80A0FFFF, b=0x20BFFFE0, cin=0 -> sum=0xA160FFDF, cout=0, OF=0.
REQ-031 Scenario 4: a=0xDFFFE8CA, b=0xCFFFF8CA, cin=1 -> sum=0xAFFFE195, cout=1, OF=0.
REQ-032 Scenario 5: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, OF=0; then a=0x7FFFFFFF, b=0, cin=1 -> sum=0x80000000, cout=0, OF=1.
REQ-033 Scenario 6: apply rst=1 while driving scenario 1 inputs -> sum=0, cout=0, OF=0 on that edge; release rst -> the scenario 1 result appears 1 cycle later.
REQ-034 A randomized comparison against a + b + cin over at least 10,000 vectors SHALL report zero mismatches.

Source files
------------

// File: rtl/carry_select_adder_32_pkg.sv
// Shared defaults for the carry-select adder and its ripple-carry groups.
package carry_select_adder_32_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int BLOCK_DEF  = 4;
  localparam int NUM_GROUPS = WIDTH_DEF / BLOCK_DEF;

endpackage

// File: rtl/carry_select_adder_32_rca_block.sv
// BLOCK-bit ripple-carry adder; also reports the carry into its MSB so the
// top level can form the signed overflow flag.
module rca_block
  import carry_select_adder_32_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK:0]   c;
  logic [BLOCK-1:0] s_c;

  always_comb begin
    c    = '0;
    s_c  = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s_c[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign s     = s_c;
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/carry_select_adder_32.sv
// Registered carry-select adder: {cout, sum} = a + b + cin one cycle later,
// plus the signed overflow flag OF. Synchronous active-high reset.
module carry_select_adder_32
  import carry_select_adder_32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             OF
);

  localparam int NG = WIDTH / BLOCK;

  logic [WIDTH-1:0] s0_w, s1_w;
  logic [NG-1:0]    co0_w, co1_w, m0_w, m1_w;

  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_grp
      if (g == 0) begin : g_first
        rca_block #(.BLOCK(BLOCK)) u_rca (
          .x     (a[BLOCK-1:0]),
          .y     (b[BLOCK-1:0]),
          .ci    (cin),
          .s     (s0_w[BLOCK-1:0]),
          .co    (co0_w[0]),
          .c_msb (m0_w[0])
        );
        // Group 0 has a single real result; mirroring it lets the select
        // chain below treat every group identically.
        assign s1_w[BLOCK-1:0] = s0_w[BLOCK-1:0];
        assign co1_w[0]        = co0_w[0];
        assign m1_w[0]         = m0_w[0];
      end else begin : g_sel
        rca_block #(.BLOCK(BLOCK)) u_rca0 (
          .x     (a[g*BLOCK +: BLOCK]),
          .y     (b[g*BLOCK +: BLOCK]),
          .ci    (1'b0),
          .s     (s0_w[g*BLOCK +: BLOCK]),
          .co    (co0_w[g]),
          .c_msb (m0_w[g])
        );
        rca_block #(.BLOCK(BLOCK)) u_rca1 (
          .x     (a[g*BLOCK +: BLOCK]),
          .y     (b[g*BLOCK +: BLOCK]),
          .ci    (1'b1),
          .s     (s1_w[g*BLOCK +: BLOCK]),
          .co    (co1_w[g]),
          .c_msb (m1_w[g])
        );
      end
    end
  endgenerate

  logic [NG:0]      carry;
  logic [WIDTH-1:0] sum_c;
  logic             c_msb;

  always_comb begin
    carry    = '0;
    sum_c    = '0;
    carry[0] = cin;
    for (int k = 0; k < NG; k++) begin
      carry[k+1]            = carry[k] ? co1_w[k] : co0_w[k];
      sum_c[k*BLOCK +: BLOCK] = carry[k] ? s1_w[k*BLOCK +: BLOCK] : s0_w[k*BLOCK +: BLOCK];
    end
    c_msb = carry[NG-1] ? m1_w[NG-1] : m0_w[NG-1];
  end

  // Only the last group's MSB carry feeds OF.
  logic unused_msb;
  assign unused_msb = ^{m0_w, m1_w};

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             of_d, of_q;

  always_comb begin
    sum_d  = sum_c;
    cout_d = carry[NG];
    of_d   = c_msb ^ carry[NG];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      of_q   <= of_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign OF   = of_q;

endmodule

// File: tb/tb_carry_select_adder_32.sv
// Self-checking bench for carry_select_adder_32: table vectors, reset
// sequences and random vectors through an expected-result queue.
module tb_carry_select_adder_32;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        OF;

  int n_cmp = 0;
  int n_bad = 0;
  res_t exp_q[$];

  carry_select_adder_32 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .OF   (OF)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
    res_t r;
    logic [32:0] t;
    t   = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (ma[31] == mb[31]) && (t[31] != ma[31]);
    return r;
  endfunction

  task automatic check(input string name, input res_t e);
    n_cmp++;
    if (sum !== e.s || cout !== e.c || OF !== e.o) begin
      n_bad++;
      $display("FAIL %s: got sum=%08h cout=%b OF=%b, expected sum=%08h cout=%b OF=%b",
               name, sum, cout, OF, e.s, e.c, e.o);
    end
  endtask

  task automatic check_pop(input string name);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got sum=%08h, expected an entry", name, sum);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  // Drive one vector on the falling edge, check its result just after the next rising edge.
  task automatic apply(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tc, input res_t e);
    @(negedge clk);
    rst = 1'b0;
    a   = ta;
    b   = tb_v;
    cin = tc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    res_t zero;
    res_t e;
    logic [31:0] ra, rb;
    logic        rc;

    zero.s = '0; zero.c = 1'b0; zero.o = 1'b0;

    tbl[0] = '{"scen1",  32'h5FFFE8CA, 32'h54F4FFFF, 1'b0, 32'hB4F4E8C9, 1'b0, 1'b1};
    tbl[1] = '{"scen2",  32'hA0A0FFFF, 32'hA0BFFFE0, 1'b0, 32'h4160FFDF, 1'b1, 1'b1};
    tbl[2] = '{"scen3",  32'h80A0FFFF, 32'h20BFFFE0, 1'b0, 32'hA160FFDF, 1'b0, 1'b0};
    tbl[3] = '{"scen4",  32'hDFFFE8CA, 32'hCFFFF8CA, 1'b1, 32'hAFFFE195, 1'b1, 1'b0};
    tbl[4] = '{"wrap_u", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[5] = '{"wrap_s", 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tbl[6] = '{"neg_of", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[7] = '{"mixed",  32'h0000000F, 32'h00000001, 1'b1, 32'h00000011, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", zero);

    foreach (tbl[i]) begin
      e.s = tbl[i].s; e.c = tbl[i].c; e.o = tbl[i].o;
      apply(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].cin, e);
    end

    // Outputs hold while inputs change between edges
    e.s = tbl[7].s; e.c = tbl[7].c; e.o = tbl[7].o;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
    #2;
    check("hold_glitch", e);

    // Reset mid-stream with scenario 1 inputs present, then release
    apply("pre_rst", tbl[1].a, tbl[1].b, tbl[1].cin, model(tbl[1].a, tbl[1].b, tbl[1].cin));
    @(negedge clk);
    rst = 1'b1; a = tbl[0].a; b = tbl[0].b; cin = tbl[0].cin;
    @(posedge clk);
    #1;
    check("rst_priority", zero);
    @(negedge clk);
    rst = 1'b0;
    e.s = tbl[0].s; e.c = tbl[0].c; e.o = tbl[0].o;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop("rst_release");

    // Random vectors, back-to-back, with occasional extreme operands
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFFFFFF;
        1: rb = 32'h7FFFFFFF;
        2: ra = 32'h80000000;
        default: ;
      endcase
      apply("random", ra, rb, rc, model(ra, rb, rc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
